sumofn_arbiter: RTL and testbench
=================================

# sumofn_arbiter

Round-robin job arbiter and sequencer that shares one `sumofN` accumulation engine between `NREQ` requesters. For each granted job it does four things in order: programs the engine's operand count through the configure port, streams the requester's operands into `in_put`, pulls the result from `out_get`, and returns that result to the requester. It sits between the client datapaths and a single `sumofN` instance, and is the only master of that instance's method ports.

## Interface
Parameters:
- `NREQ`, 2, number of requesters (2..4).
- `W`, 8, operand, count and result width; must match `sumofN`.
- `CNT_ADDR`, 8'd1, configure address of the engine's count register.

Ports:
- `CLK` in 1: single clock, all state on posedge.
- `RST_N` in 1: asynchronous active-low reset.
- `req_valid` in NREQ: per-requester job request.
- `req_count` in NREQ*W: per-requester operand count; requester i uses bits [i*W +: W].
- `req_ready` out NREQ: one-hot job accept.
- `op_data` in NREQ*W: per-requester operand.
- `op_valid` in NREQ: operand valid.
- `op_ready` out NREQ: operand accept; only the granted bit can be 1.
- `rsp_data` out W: result, shared by all requesters.
- `rsp_valid` out NREQ: one-hot response valid.
- `rsp_ready` in NREQ: response accept.
- `busy` out 1: high in every state except IDLE.
- `grant` out 2: index of the current or last granted requester.
- Engine-side ports, connected 1:1 to `sumofN`:
  - `eng_in_put` out W, `eng_EN_in_put` out 1, `eng_RDY_in_put` in 1.
  - `eng_EN_out_get` out 1, `eng_out_get` in W, `eng_RDY_out_get` in 1.
  - `eng_configure_address` out 8, `eng_configure_data` out W.
  - `eng_EN_configure` out 1, `eng_RDY_configure` in 1.

## Operation
- State register values: IDLE, CONFIG, STREAM, WAIT, RESPOND.
- Round-robin pointer `rr` holds the requester with highest priority.
- IDLE:
  - Scan `req_valid` starting at `rr`; the first set bit g is granted.
  - `req_ready[g]`=1 for that cycle.
  - Latch g into `grant` and `req_count[g]` into `remain`.
  - If count ≠ 0, go to CONFIG.
  - If count = 0, load `rsp_reg`=0 and go to RESPOND; the engine is untouched.
- CONFIG:
  - Drive `eng_configure_address`=`CNT_ADDR` and `eng_configure_data`=count.
  - `eng_EN_configure`=`eng_RDY_configure`.
  - On the cycle it fires, go to STREAM.
- STREAM:
  - `eng_in_put`=`op_data[g]`.
  - `op_ready[g]`=`eng_RDY_in_put`.
  - `eng_EN_in_put`=`op_valid[g]` & `eng_RDY_in_put`.
  - Each transfer decrements `remain`.
  - The transfer made with `remain`=1 moves to WAIT.
  - Operands from non-granted requesters are never accepted.
- WAIT:
  - `eng_EN_out_get`=`eng_RDY_out_get`.
  - On fire, capture `eng_out_get` into `rsp_reg` and go to RESPOND.
- RESPOND:
  - `rsp_data`=`rsp_reg`, `rsp_valid[g]`=1.
  - When `rsp_ready[g]`=1, set `rr`=(g+1) mod NREQ and go to IDLE.
- Arithmetic:
  - Sum wrap-around modulo 2^W is performed by the engine; the arbiter passes the result through unmodified.
  - `remain` is W bits; maximum job size is 2^W−1 operands.
- The engine `interrupt` is not used; completion is detected only via `eng_RDY_out_get`.

## Timing
- Reset values: state=IDLE, `rr`=0, `grant`=0, `remain`=0, `rsp_reg`=0.
- All outputs are 0 in reset: `req_ready`, `op_ready`, `rsp_valid`, every `eng_EN_*`, `eng_configure_*`, `eng_in_put`, `busy`.
- Reset is asynchronous and takes effect mid-job with no drain. The engine shares `RST_N`, so both restart clean.
- Minimum job latency, request accept to `rsp_valid`, for N operands with no backpressure:
  - Cycle 0: IDLE, grant.
  - Cycle 1: CONFIG.
  - Cycles 2..N+1: STREAM.
  - WAIT: lasts until the engine asserts `eng_RDY_out_get`.
  - The next cycle after the get fires: RESPOND.
- Count 0: `rsp_valid` is high in the cycle after the grant.
- At most one `eng_EN_*` is high in any cycle.
- `req_ready`, `op_ready` and `rsp_valid` are each zero or one-hot.
- Simultaneous requests in IDLE: the lowest index at or after `rr` wins. The losers hold `req_valid` and are served in later jobs.
- A requester that drops `op_valid` stalls STREAM indefinitely; there is no timeout.
- `rsp_ready` held low stalls RESPOND indefinitely.
- A new grant can occur no earlier than the cycle after the RESPOND handshake.

## Test plan
- Job on requester 0 with count 3, operands 0x0F×3 → one `EN_configure` with addr 1 and data 3, exactly 3 `EN_in_put`, then `rsp_valid[0]` with `rsp_data`=0x2D.
- Requesters 0 and 1 both request from reset, count 2 with 0x01,0x02 and count 2 with 0x10,0x20 → req0 is served first (0x03), then req1 (0x30). Requester 0 then re-requests while requester 1 also requests → requester 0 wins again only after requester 1 has been served (rr=0 after requester 1's job); a follow-on test with requester 1 requesting at rr=1 → requester 1 is granted first.
- Requester 1 issues count 0 → `rsp_valid[1]`=1 with data 0 one cycle after grant, and no `eng_EN_*` pulses.
- Count 4 with 0x80 operands; `eng_RDY_in_put` is low for 3 cycles mid-stream and `op_valid` has gaps → exactly 4 transfers, `rsp_data`=0x00 (wrap modulo 256), and `op_ready` is low while RDY is low.
- `rsp_ready` held low for 5 cycles → `rsp_valid` and `rsp_data` stay stable, and a pending `req_valid` from the other requester is not granted until the handshake completes.
- `RST_N` asserted during STREAM after 2 of 5 operands → all outputs are 0 immediately. After release, a fresh count 2 job with 0x0F,0x0F returns 0x1E.

Source files
------------

// File: rtl/sumofn_arbiter.sv
// Round-robin job sequencer sharing one sumofN engine between NREQ requesters:
// configure count, stream operands, fetch the sum, hand it back to the requester.
module sumofn_arbiter #(
    parameter int          NREQ     = 2,
    parameter int          W        = 8,
    parameter logic [7:0]  CNT_ADDR = 8'd1
) (
    input  logic                CLK,
    input  logic                RST_N,
    input  logic [NREQ-1:0]     req_valid,
    input  logic [NREQ*W-1:0]   req_count,
    output logic [NREQ-1:0]     req_ready,
    input  logic [NREQ*W-1:0]   op_data,
    input  logic [NREQ-1:0]     op_valid,
    output logic [NREQ-1:0]     op_ready,
    output logic [W-1:0]        rsp_data,
    output logic [NREQ-1:0]     rsp_valid,
    input  logic [NREQ-1:0]     rsp_ready,
    output logic                busy,
    output logic [1:0]          grant,
    output logic [W-1:0]        eng_in_put,
    output logic                eng_EN_in_put,
    input  logic                eng_RDY_in_put,
    output logic                eng_EN_out_get,
    input  logic [W-1:0]        eng_out_get,
    input  logic                eng_RDY_out_get,
    output logic [7:0]          eng_configure_address,
    output logic [W-1:0]        eng_configure_data,
    output logic                eng_EN_configure,
    input  logic                eng_RDY_configure
);

    typedef enum logic [2:0] {IDLE, CONFIG, STREAM, WAIT, RESPOND} state_t;

    state_t          state;
    logic [1:0]      rr;
    logic [W-1:0]    remain;
    logic [W-1:0]    rsp_reg;

    logic [NREQ-1:0] hi;
    logic [NREQ-1:0] cand;
    logic [NREQ-1:0] pick_sel;
    logic [NREQ-1:0] gsel;
    logic            found;
    logic [1:0]      pick;
    logic [W-1:0]    pick_count;
    logic [W-1:0]    g_data;
    logic            g_valid;
    logic            g_rsp_ready;

    // Requests at or above rr take priority; otherwise wrap to the lowest index.
    always_comb begin
        hi         = '0;
        pick       = '0;
        pick_count = '0;
        pick_sel   = '0;
        for (int j = 0; j < NREQ; j++) begin
            hi[j] = req_valid[j] && (j >= int'(rr));
        end
        cand  = (hi != '0) ? hi : req_valid;
        found = |cand;
        for (int j = NREQ - 1; j >= 0; j--) begin
            if (cand[j]) begin
                pick       = 2'(j);
                pick_count = req_count[j*W +: W];
            end
        end
        for (int j = 0; j < NREQ; j++) begin
            pick_sel[j] = found && (pick == 2'(j));
        end
    end

    always_comb begin
        gsel        = '0;
        g_data      = '0;
        g_valid     = 1'b0;
        g_rsp_ready = 1'b0;
        for (int j = 0; j < NREQ; j++) begin
            gsel[j] = (grant == 2'(j));
            if (grant == 2'(j)) begin
                g_data      = op_data[j*W +: W];
                g_valid     = op_valid[j];
                g_rsp_ready = rsp_ready[j];
            end
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state   <= IDLE;
            rr      <= '0;
            grant   <= '0;
            remain  <= '0;
            rsp_reg <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (found) begin
                        grant  <= pick;
                        remain <= pick_count;
                        if (pick_count != '0) begin
                            state <= CONFIG;
                        end else begin
                            rsp_reg <= '0;
                            state   <= RESPOND;
                        end
                    end
                end
                CONFIG: begin
                    if (eng_RDY_configure) state <= STREAM;
                end
                STREAM: begin
                    if (g_valid && eng_RDY_in_put) begin
                        remain <= remain - W'(1);
                        if (remain == W'(1)) state <= WAIT;
                    end
                end
                WAIT: begin
                    if (eng_RDY_out_get) begin
                        rsp_reg <= eng_out_get;
                        state   <= RESPOND;
                    end
                end
                RESPOND: begin
                    if (g_rsp_ready) begin
                        rr    <= (int'(grant) == NREQ - 1) ? 2'd0 : grant + 2'd1;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // req_ready is gated by RST_N so nothing is accepted while reset is held.
    assign req_ready             = (state == IDLE && RST_N) ? pick_sel : '0;
    assign op_ready              = (state == STREAM && eng_RDY_in_put) ? gsel : '0;
    assign rsp_valid             = (state == RESPOND) ? gsel : '0;
    assign rsp_data              = rsp_reg;
    assign busy                  = (state != IDLE);
    assign eng_in_put            = (state == STREAM) ? g_data : '0;
    assign eng_EN_in_put         = (state == STREAM) && g_valid && eng_RDY_in_put;
    assign eng_EN_out_get        = (state == WAIT) && eng_RDY_out_get;
    assign eng_configure_address = (state == CONFIG) ? CNT_ADDR : 8'd0;
    assign eng_configure_data    = (state == CONFIG) ? remain : '0;
    assign eng_EN_configure      = (state == CONFIG) && eng_RDY_configure;

endmodule

// File: tb/tb_sumofn_arbiter.sv
// Scoreboarded bench for sumofn_arbiter with a behavioural sumofN engine model
// and randomized requester traffic.
module tb_sumofn_arbiter;

    logic        CLK = 1'b0;
    logic        RST_N = 1'b1;
    logic [1:0]  req_valid = '0;
    logic [15:0] req_count = '0;
    logic [1:0]  req_ready;
    logic [15:0] op_data = '0;
    logic [1:0]  op_valid = '0;
    logic [1:0]  op_ready;
    logic [7:0]  rsp_data;
    logic [1:0]  rsp_valid;
    logic [1:0]  rsp_ready = '0;
    logic        busy;
    logic [1:0]  grant;
    logic [7:0]  eng_in_put;
    logic        eng_EN_in_put;
    logic        eng_RDY_in_put = 1'b0;
    logic        eng_EN_out_get;
    logic [7:0]  eng_out_get = '0;
    logic        eng_RDY_out_get = 1'b0;
    logic [7:0]  eng_configure_address;
    logic [7:0]  eng_configure_data;
    logic        eng_EN_configure;
    logic        eng_RDY_configure = 1'b0;

    sumofn_arbiter #(.NREQ(2), .W(8), .CNT_ADDR(8'd1)) dut (
        .CLK(CLK), .RST_N(RST_N),
        .req_valid(req_valid), .req_count(req_count), .req_ready(req_ready),
        .op_data(op_data), .op_valid(op_valid), .op_ready(op_ready),
        .rsp_data(rsp_data), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .busy(busy), .grant(grant),
        .eng_in_put(eng_in_put), .eng_EN_in_put(eng_EN_in_put), .eng_RDY_in_put(eng_RDY_in_put),
        .eng_EN_out_get(eng_EN_out_get), .eng_out_get(eng_out_get), .eng_RDY_out_get(eng_RDY_out_get),
        .eng_configure_address(eng_configure_address), .eng_configure_data(eng_configure_data),
        .eng_EN_configure(eng_EN_configure), .eng_RDY_configure(eng_RDY_configure)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        int         idx;
        int         cnt;
        logic [7:0] sum;
    } exp_t;

    exp_t exp_q[$];
    int   tests = 0;
    int   fails = 0;

    // engine model state
    bit         e_act = 1'b0;
    int         e_cnt = 0;
    int         e_n = 0;
    logic [7:0] e_acc = '0;
    int         in_stall = 0;

    // monitor state
    bit         job_open = 1'b0;
    int         cur = 0;
    int         cur_cnt = 0;
    int         cfg_n = 0;
    int         put_n = 0;
    int         rr_m = 0;
    int         win = 0;
    logic [1:0] prev_rv = '0;
    bit         prev_hs = 1'b0;
    logic [7:0] prev_data = '0;
    logic [1:0] hs, rh, mask;
    exp_t       e_pop;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic void timeout(input string name);
        tests++;
        fails++;
        $display("FAIL %s: wait bound expired at %0t", name, $time);
    endfunction

    task automatic check_all_zero(input string tag);
        chk({tag, "_ctrl"}, 32'({req_ready, op_ready, rsp_valid, busy, grant,
                                 eng_EN_in_put, eng_EN_out_get, eng_EN_configure}), 32'd0);
        chk({tag, "_data"}, {rsp_data, eng_in_put, eng_configure_address, eng_configure_data}, 32'd0);
    endtask

    // sumofN engine: accepts a count, accumulates that many operands, offers the sum.
    initial forever begin
        @(negedge CLK);
        if (!RST_N) begin
            e_act = 1'b0; e_cnt = 0; e_n = 0; e_acc = '0;
        end else begin
            if (eng_EN_configure) begin
                e_act = 1'b1; e_cnt = int'(eng_configure_data); e_n = 0; e_acc = '0;
            end
            if (eng_EN_in_put) begin
                e_acc = e_acc + eng_in_put;
                e_n++;
            end
            if (eng_EN_out_get) e_act = 1'b0;
        end
    end

    initial forever begin
        @(posedge CLK);
        #1;
        eng_RDY_configure = RST_N && !e_act && ($urandom_range(0, 3) != 0);
        if (in_stall > 0) begin
            eng_RDY_in_put = 1'b0;
            in_stall--;
        end else begin
            eng_RDY_in_put = RST_N && e_act && (e_n < e_cnt) && ($urandom_range(0, 3) != 0);
        end
        eng_RDY_out_get = RST_N && e_act && (e_n == e_cnt) && ($urandom_range(0, 2) != 0);
        eng_out_get     = (e_act && e_n == e_cnt) ? e_acc : 8'($urandom);
    end

    // Monitor: protocol rules every cycle, scoreboard pop on each response handshake.
    initial forever begin
        @(negedge CLK);
        if (!RST_N) begin
            job_open = 1'b0; rr_m = 0; prev_rv = '0; prev_hs = 1'b0; cfg_n = 0; put_n = 0;
        end else begin
            chk("en_exclusive", 32'(int'(eng_EN_configure) + int'(eng_EN_in_put) + int'(eng_EN_out_get) <= 1), 32'd1);
            chk("req_ready_onehot", 32'(req_ready != 2'b11), 32'd1);
            chk("op_ready_onehot", 32'(op_ready != 2'b11), 32'd1);
            chk("rsp_valid_onehot", 32'(rsp_valid != 2'b11), 32'd1);
            chk("en_cfg_vs_rdy", 32'(eng_EN_configure && !eng_RDY_configure), 32'd0);
            chk("en_put_vs_rdy", 32'(eng_EN_in_put && !eng_RDY_in_put), 32'd0);
            chk("en_get_vs_rdy", 32'(eng_EN_out_get && !eng_RDY_out_get), 32'd0);
            mask = job_open ? (2'b01 << cur) : 2'b00;
            chk("op_ready_scope", 32'(op_ready & ~mask), 32'd0);
            if (!eng_RDY_in_put) chk("op_ready_vs_rdy", 32'(op_ready), 32'd0);
            chk("busy", 32'(busy), 32'(job_open));
            if (job_open) chk("no_grant_while_busy", 32'(req_ready), 32'd0);
            if (prev_rv != 2'b00 && !prev_hs) begin
                chk("rsp_valid_hold", 32'(rsp_valid), 32'(prev_rv));
                chk("rsp_data_hold", 32'(rsp_data), 32'(prev_data));
            end
            if (eng_EN_configure) begin
                cfg_n++;
                chk("cfg_addr", 32'(eng_configure_address), 32'd1);
                chk("cfg_data", 32'(eng_configure_data), 32'(cur_cnt));
                chk("cfg_nonzero_job", 32'(cur_cnt != 0), 32'd1);
            end
            if (eng_EN_in_put) put_n++;
            hs = req_valid & req_ready;
            if (hs != 2'b00) begin
                win = -1;
                for (int k = 0; k < 2; k++) begin
                    int c;
                    c = (rr_m + k) % 2;
                    if (win < 0 && req_valid[c[0]]) win = c;
                end
                chk("arb_winner", 32'(hs), 32'(2'b01 << win));
                job_open = 1'b1;
                cur      = win;
                cur_cnt  = int'(req_count[win*8 +: 8]);
                cfg_n    = 0;
                put_n    = 0;
            end
            rh = rsp_valid & rsp_ready;
            if (rh != 2'b00) begin
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL sb_unexpected: response %b with no job outstanding", rh);
                end else begin
                    e_pop = exp_q.pop_front();
                    chk("rsp_who", 32'(rh), 32'(2'b01 << e_pop.idx));
                    chk("rsp_data", 32'(rsp_data), 32'(e_pop.sum));
                    chk("put_count", 32'(put_n), 32'(e_pop.cnt));
                    chk("cfg_count", 32'(cfg_n), 32'(e_pop.cnt != 0));
                    chk("grant_out", 32'(grant), 32'(e_pop.idx));
                    rr_m = (e_pop.idx + 1) % 2;
                end
                job_open = 1'b0;
            end
            prev_rv   = rsp_valid;
            prev_hs   = (rh != 2'b00);
            prev_data = rsp_data;
        end
    end

    // One requester job. mode 0: random operands, 1: all base, 2: base*(n+1).
    task automatic run_job(input int i, input int cnt, input int mode, input logic [7:0] base,
                           input int gap, input int rdly);
        logic [7:0] ops[$];
        logic [7:0] sum;
        logic [7:0] o;
        int         k;
        int         t;
        exp_t       e;
        sum = '0;
        for (int n = 0; n < cnt; n++) begin
            o = (mode == 0) ? 8'($urandom) : (mode == 1) ? base : 8'(int'(base) * (n + 1));
            ops.push_back(o);
            sum = sum + o;
        end
        req_count[i*8 +: 8] = 8'(cnt);
        req_valid[i] = 1'b1;
        t = 0;
        do begin @(negedge CLK); t++; end while (!req_ready[i] && t < 3000);
        if (!req_ready[i]) begin
            timeout("req_grant");
            req_valid[i] = 1'b0;
            return;
        end
        e.idx = i; e.cnt = cnt; e.sum = sum;
        exp_q.push_back(e);
        @(posedge CLK); #1 req_valid[i] = 1'b0;
        k = 0;
        t = 0;
        while (k < cnt && t < 3000) begin
            op_valid[i] = ($urandom_range(0, 99) >= gap);
            op_data[i*8 +: 8] = ops[k];
            @(negedge CLK);
            t++;
            if (op_valid[i] && op_ready[i]) k++;
            @(posedge CLK); #1;
        end
        op_valid[i] = 1'b0;
        if (k < cnt) begin
            timeout("op_stream");
            return;
        end
        t = 0;
        do begin @(negedge CLK); t++; end while (!rsp_valid[i] && t < 3000);
        if (!rsp_valid[i]) begin
            timeout("rsp_wait");
            return;
        end
        if (cnt == 0) chk("zero_count_latency", 32'(t), 32'd1);
        repeat (rdly) @(negedge CLK);
        @(posedge CLK); #1 rsp_ready[i] = 1'b1;
        @(negedge CLK);
        @(posedge CLK); #1 rsp_ready[i] = 1'b0;
    endtask

    initial begin
        int k;
        int t;
        #2 RST_N = 1'b0;
        repeat (3) @(posedge CLK);
        #1;
        check_all_zero("reset_state");
        RST_N = 1'b1;
        @(posedge CLK); #1;

        run_job(0, 3, 1, 8'h0F, 0, 0);

        fork
            run_job(0, 2, 2, 8'h01, 0, 0);
            run_job(1, 2, 2, 8'h10, 0, 0);
        join
        fork
            run_job(0, 2, 0, 8'h00, 10, 1);
            run_job(1, 3, 0, 8'h00, 10, 0);
        join
        run_job(0, 1, 0, 8'h00, 0, 0);
        fork
            run_job(0, 2, 0, 8'h00, 0, 0);
            run_job(1, 2, 0, 8'h00, 0, 0);
        join

        run_job(1, 0, 0, 8'h00, 0, 0);

        fork
            run_job(0, 4, 1, 8'h80, 30, 0);
            begin
                t = 0;
                while (!(e_act && e_cnt == 4 && e_n >= 2) && t < 3000) begin
                    @(posedge CLK); #1;
                    t++;
                end
                in_stall = 3;
            end
        join

        fork
            run_job(0, 2, 0, 8'h00, 0, 5);
            begin
                repeat (3) @(posedge CLK);
                #1;
                run_job(1, 1, 0, 8'h00, 0, 0);
            end
        join

        fork
            for (int j = 0; j < 8; j++) begin
                run_job(0, $urandom_range(0, 6), 0, 8'h00, $urandom_range(0, 40), $urandom_range(0, 3));
                repeat ($urandom_range(0, 2)) begin @(posedge CLK); #1; end
            end
            for (int j = 0; j < 8; j++) begin
                run_job(1, $urandom_range(0, 6), 0, 8'h00, $urandom_range(0, 40), $urandom_range(0, 3));
                repeat ($urandom_range(0, 2)) begin @(posedge CLK); #1; end
            end
        join

        // Mid-stream reset: 2 of 5 operands sent, then RST_N asserted.
        req_count[7:0] = 8'd5;
        req_valid[0] = 1'b1;
        t = 0;
        do begin @(negedge CLK); t++; end while (!req_ready[0] && t < 100);
        chk("reset_job_grant", 32'(req_ready[0]), 32'd1);
        @(posedge CLK); #1;
        req_valid[0] = 1'b0;
        op_valid[0] = 1'b1;
        op_data[7:0] = 8'h0F;
        k = 0;
        t = 0;
        while (k < 2 && t < 3000) begin
            @(negedge CLK);
            t++;
            if (op_ready[0]) k++;
            @(posedge CLK); #1;
        end
        op_valid[0] = 1'b0;
        req_valid[1] = 1'b1;
        RST_N = 1'b0;
        #1;
        check_all_zero("reset_midjob");
        repeat (2) @(posedge CLK);
        #1;
        req_valid[1] = 1'b0;
        RST_N = 1'b1;
        @(posedge CLK); #1;
        run_job(0, 2, 1, 8'h0F, 0, 0);

        repeat (3) @(posedge CLK);
        chk("sb_drain", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
